// File: rtl/abus_slave_regfile.sv
// abus responder: NB_REGS registers at BASE_ADDR, programmable wait states, abort, flat register export.
// Optional macro ABUS_SLAVE_MID_FILTER_EN: writes allowed only from master ids set in WRITE_MID_MASK.
module abus_slave_regfile #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int BASE_ADDR = 0,
   parameter int NB_REGS = 8,
   parameter int WAIT_STATES = 1,
   parameter logic [7:0] WRITE_MID_MASK = 8'hFF,
   localparam int SW = $clog2(DATA_WIDTH + 1)
) (
   input  logic                          abus_clk,
   input  logic                          abus_rstb,
   input  logic [2:0]                    abus_smid,
   input  logic                          abus_sreq,
   input  logic                          abus_swrite,
   input  logic                          abus_sread,
   input  logic                          abus_sabort,
   input  logic [SW-1:0]                 abus_sstrb,
   input  logic [SW-1:0]                 abus_skeep,
   input  logic [ADDR_WIDTH-1:0]         abus_saddress,
   input  logic [DATA_WIDTH-1:0]         abus_swdata,
   output logic                          abus_sack,
   output logic [DATA_WIDTH-1:0]         abus_srdata,
   output logic                          busy,
   output logic [NB_REGS*DATA_WIDTH-1:0] reg_q
);
   localparam int OW = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
   localparam logic [ADDR_WIDTH:0] LO_ADDR = (ADDR_WIDTH + 1)'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] NB_EXT = (ADDR_WIDTH + 1)'(NB_REGS);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACK = 2'd2} state_t;

   state_t                    state_q, state_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [2:0]                mid_q;
   logic [OW-1:0]             off_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [SW-1:0]             strb_q, keep_q;
   logic                      wr_q;
   logic                      sack_q, sack_d, busy_q;
   logic [DATA_WIDTH-1:0]     srdata_q, srdata_d;
   logic [NB_REGS*DATA_WIDTH-1:0] reg_d;

   logic [ADDR_WIDTH:0]       addr_diff_s;
   logic                      hit_s, idle_s, accept_s, commit_s;
   logic                      op_wr_s, mid_ok_s, wr_ok_s;
   logic [2:0]                op_mid_s;
   logic [OW-1:0]             op_off_s;
   logic [DATA_WIDTH-1:0]     op_wdata_s, cur_s, wmask_s;
   logic [SW-1:0]             op_strb_s, op_keep_s;

   // Mask of the n low bits; counts above DATA_WIDTH saturate to all ones.
   function automatic logic [DATA_WIDTH-1:0] low_mask(input logic [SW-1:0] n);
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         m[i] = (i < int'(n));
      end
      return m;
   endfunction

   // Wrap-around subtraction on one extra bit turns the range check into a single compare.
   assign addr_diff_s = {1'b0, abus_saddress} - LO_ADDR;
   assign hit_s       = (addr_diff_s < NB_EXT);
   assign idle_s      = (state_q == ST_IDLE);
   assign accept_s    = idle_s && abus_sreq && hit_s && !abus_sabort && (abus_sread || abus_swrite);

   // With zero wait states the commit happens on the accept edge, so live inputs are used then.
   assign op_wr_s    = idle_s ? (abus_swrite && !abus_sread) : wr_q;
   assign op_mid_s   = idle_s ? abus_smid : mid_q;
   assign op_off_s   = idle_s ? OW'(addr_diff_s) : off_q;
   assign op_wdata_s = idle_s ? abus_swdata : wdata_q;
   assign op_strb_s  = idle_s ? abus_sstrb : strb_q;
   assign op_keep_s  = idle_s ? abus_skeep : keep_q;

   assign mid_ok_s = WRITE_MID_MASK[op_mid_s];
`ifdef ABUS_SLAVE_MID_FILTER_EN
   assign wr_ok_s = mid_ok_s;
`else
   assign wr_ok_s = mid_ok_s | 1'b1;
`endif

   assign cur_s   = reg_q[int'(op_off_s) * DATA_WIDTH +: DATA_WIDTH];
   assign wmask_s = low_mask(op_strb_s);

   // Next-state logic; abort in WAIT takes priority over counter expiry.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      commit_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (WAIT_STATES == 0) begin
                  state_d  = ST_ACK;
                  commit_s = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 8'(WAIT_STATES);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (abus_sabort) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else if (cnt_q == 8'd1) begin
               state_d  = ST_ACK;
               cnt_d    = 8'd0;
               commit_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Commit datapath: register update, ack and read data all take effect on the ACK entry edge.
   always_comb begin
      reg_d    = reg_q;
      sack_d   = 1'b0;
      srdata_d = '0;
      if (commit_s) begin
         sack_d = 1'b1;
         if (op_wr_s) begin
            if (wr_ok_s) begin
               reg_d[int'(op_off_s) * DATA_WIDTH +: DATA_WIDTH] = (cur_s & ~wmask_s) | (op_wdata_s & wmask_s);
            end else begin
               reg_d = reg_q;
            end
         end else begin
            srdata_d = cur_s & low_mask(op_keep_s);
         end
      end else begin
         sack_d = 1'b0;
      end
   end

   // State, outputs and latched request fields.
   always_ff @(posedge abus_clk or negedge abus_rstb) begin
      if (!abus_rstb) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         busy_q   <= 1'b0;
         sack_q   <= 1'b0;
         srdata_q <= '0;
         reg_q    <= '0;
         mid_q    <= 3'd0;
         off_q    <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         keep_q   <= '0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= (state_d != ST_IDLE);
         sack_q   <= sack_d;
         srdata_q <= srdata_d;
         reg_q    <= reg_d;
         if (accept_s) begin
            mid_q   <= abus_smid;
            off_q   <= OW'(addr_diff_s);
            wdata_q <= abus_swdata;
            strb_q  <= abus_sstrb;
            keep_q  <= abus_skeep;
            wr_q    <= abus_swrite && !abus_sread;
         end
      end
   end

   assign abus_sack   = sack_q;
   assign abus_srdata = srdata_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_abus_slave_regfile.sv
// Bench: three slaves on one shared request bus (bases 0x10/0x20/0x30, wait states 1/3/0),
// table-driven register vectors plus abort, out-of-range, back-to-back and reset sequences.
module tb_abus_slave_regfile;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int NR = 8;
   localparam int SW = $clog2(DW + 1);
`ifdef ABUS_SLAVE_MID_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic [2:0] smid;
   logic sreq, swrite, sread, sabort;
   logic [SW-1:0] sstrb, skeep;
   logic [AW-1:0] saddr;
   logic [DW-1:0] swdata;
   logic [2:0] sack, busy;
   logic [DW-1:0] srdata [3];
   logic [NR*DW-1:0] regs [3];

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {int dut; logic [DW-1:0] rdata; int cyc;} exp_t;
   exp_t sb[$];

   typedef struct {
      logic [2:0] mid; bit wr; bit rd; logic [AW-1:0] addr; logic [DW-1:0] wd;
      logic [SW-1:0] st; logic [SW-1:0] kp; logic [DW-1:0] erd; int ridx; logic [DW-1:0] ereg;
   } vec_t;
   vec_t tv[14];

   for (genvar k = 0; k < 3; k++) begin : g_dut
      abus_slave_regfile #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(16 + 16 * k), .NB_REGS(NR),
         .WAIT_STATES((k == 0) ? 1 : ((k == 1) ? 3 : 0)), .WRITE_MID_MASK(8'h01)
      ) u_dut (
         .abus_clk(clk), .abus_rstb(rstb), .abus_smid(smid), .abus_sreq(sreq),
         .abus_swrite(swrite), .abus_sread(sread), .abus_sabort(sabort),
         .abus_sstrb(sstrb), .abus_skeep(skeep), .abus_saddress(saddr), .abus_swdata(swdata),
         .abus_sack(sack[k]), .abus_srdata(srdata[k]), .busy(busy[k]), .reg_q(regs[k])
      );
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wst(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one request for a single cycle (starting #1 after a posedge), then scrambles the bus.
   task automatic req(input logic [2:0] mid, input bit wr, input bit rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [SW-1:0] st, input logic [SW-1:0] kp,
                      input int dut, input logic [DW-1:0] erd);
      exp_t e;
      smid = mid; swrite = wr; sread = rd; saddr = a; swdata = wd; sstrb = st; skeep = kp; sreq = 1'b1;
      if (dut >= 0) begin
         e.dut = dut; e.rdata = erd; e.cyc = cyc + 1 + wst(dut);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      sreq = 1'b0; swdata = ~swdata; saddr = saddr ^ 16'h0001; smid = smid ^ 3'd1;
      sstrb = '0; skeep = '0;
   endtask

   // Every cycle: the expected ack (if due) must be present with its data, all other slaves silent.
   task automatic monitor();
      int hk;
      exp_t e;
      forever begin
         @(negedge clk);
         hk = -1;
         if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            hk = e.dut;
            chk($sformatf("sack_d%0d", e.dut), 32'(sack[e.dut]), 32'd1);
            chk($sformatf("srdata_d%0d", e.dut), 32'(srdata[e.dut]), 32'(e.rdata));
         end
         for (int k = 0; k < 3; k++) begin
            if (k != hk) begin
               chk($sformatf("no_sack_d%0d", k), 32'(sack[k]), 32'd0);
               chk($sformatf("srdata_zero_d%0d", k), 32'(srdata[k]), 32'd0);
            end
         end
      end
   endtask

   initial begin
      smid = 3'd0; sreq = 1'b0; swrite = 1'b0; sread = 1'b0; sabort = 1'b0;
      sstrb = '0; skeep = '0; saddr = '0; swdata = '0;
      fork
         monitor();
      join_none
      idle(3);
      rstb = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_busy_d%0d", k), 32'(busy[k]), 32'd0);
         chk($sformatf("rst_regs_d%0d", k), 32'(|regs[k]), 32'd0);
      end

      tv[0]  = '{3'd0, 1'b1, 1'b0, 16'h0012, 16'hA5A5, 5'd16, 5'd16, 16'h0000, 2, 16'hA5A5};
      tv[1]  = '{3'd0, 1'b0, 1'b1, 16'h0012, 16'h0000, 5'd0,  5'd16, 16'hA5A5, 2, 16'hA5A5};
      tv[2]  = '{3'd0, 1'b1, 1'b0, 16'h0012, 16'hFFFF, 5'd16, 5'd0,  16'h0000, 2, 16'hFFFF};
      tv[3]  = '{3'd0, 1'b1, 1'b0, 16'h0012, 16'h0000, 5'd4,  5'd0,  16'h0000, 2, 16'hFFF0};
      tv[4]  = '{3'd0, 1'b0, 1'b1, 16'h0012, 16'h0000, 5'd0,  5'd8,  16'h00F0, 2, 16'hFFF0};
      tv[5]  = '{3'd0, 1'b0, 1'b1, 16'h0012, 16'h0000, 5'd0,  5'd31, 16'hFFF0, 2, 16'hFFF0};
      tv[6]  = '{3'd0, 1'b1, 1'b0, 16'h0017, 16'h1234, 5'd0,  5'd0,  16'h0000, 7, 16'h0000};
      tv[7]  = '{3'd0, 1'b1, 1'b0, 16'h0017, 16'hABCD, 5'd20, 5'd0,  16'h0000, 7, 16'hABCD};
      tv[8]  = '{3'd0, 1'b0, 1'b1, 16'h0017, 16'h0000, 5'd0,  5'd0,  16'h0000, 7, 16'hABCD};
      tv[9]  = '{3'd0, 1'b1, 1'b1, 16'h0017, 16'h0000, 5'd16, 5'd16, 16'hABCD, 7, 16'hABCD};
      tv[10] = '{3'd1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 5'd16, 5'd0,  16'h0000, 0, FILT ? 16'h0000 : 16'hBEEF};
      tv[11] = '{3'd0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 5'd16, 5'd0,  16'h0000, 0, 16'hBEEF};
      tv[12] = '{3'd3, 1'b0, 1'b1, 16'h0010, 16'h0000, 5'd0,  5'd12, 16'h0EEF, 0, 16'hBEEF};
      tv[13] = '{3'd0, 1'b1, 1'b0, 16'h0013, 16'h0001, 5'd1,  5'd0,  16'h0000, 3, 16'h0001};
      for (int i = 0; i < 14; i++) begin
         req(tv[i].mid, tv[i].wr, tv[i].rd, tv[i].addr, tv[i].wd, tv[i].st, tv[i].kp, 0, tv[i].erd);
         idle(3);
         chk($sformatf("vec%0d_reg%0d", i, tv[i].ridx), 32'(regs[0][tv[i].ridx * DW +: DW]), 32'(tv[i].ereg));
      end

      // Three wait states: write then read back on the second slave.
      req(3'd0, 1'b1, 1'b0, 16'h0021, 16'h5A5A, 5'd16, 5'd0, 1, 16'h0000);
      idle(5);
      chk("ws3_write_reg1", 32'(regs[1][1 * DW +: DW]), 32'h5A5A);
      req(3'd0, 1'b0, 1'b1, 16'h0021, 16'h0000, 5'd0, 5'd16, 1, 16'h5A5A);
      idle(5);

      // Abort in the first WAIT cycle, then abort in the cycle where the counter would expire.
      req(3'd0, 1'b1, 1'b0, 16'h0022, 16'h1234, 5'd16, 5'd16, -1, 16'h0000);
      sabort = 1'b1;
      chk("abort_busy_before", 32'(busy[1]), 32'd1);
      idle(1);
      sabort = 1'b0;
      chk("abort_busy_after", 32'(busy[1]), 32'd0);
      idle(5);
      chk("abort_reg2", 32'(regs[1][2 * DW +: DW]), 32'h0000);
      req(3'd0, 1'b1, 1'b0, 16'h0022, 16'h4321, 5'd16, 5'd16, -1, 16'h0000);
      idle(2);
      sabort = 1'b1;
      idle(1);
      sabort = 1'b0;
      chk("abort_late_busy", 32'(busy[1]), 32'd0);
      idle(5);
      chk("abort_late_reg2", 32'(regs[1][2 * DW +: DW]), 32'h0000);

      // Unowned address held for 20 cycles.
      smid = 3'd0; swrite = 1'b1; sread = 1'b0; saddr = 16'h0018; swdata = 16'hFFFF; sstrb = 5'd16; sreq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         chk("miss_busy", 32'(busy), 32'd0);
      end
      sreq = 1'b0;
      idle(2);

      // Zero wait states: preload, then back-to-back reads from two masters.
      req(3'd0, 1'b1, 1'b0, 16'h0030, 16'h1111, 5'd16, 5'd0, 2, 16'h0000);
      idle(2);
      req(3'd0, 1'b1, 1'b0, 16'h0031, 16'h2222, 5'd16, 5'd0, 2, 16'h0000);
      idle(2);
      begin
         exp_t e;
         smid = 3'd2; sread = 1'b1; swrite = 1'b0; saddr = 16'h0030; skeep = 5'd16; sreq = 1'b1;
         e.dut = 2; e.rdata = 16'h1111; e.cyc = cyc + 1;
         sb.push_back(e);
         idle(1);
         smid = 3'd5; saddr = 16'h0031;
         e.dut = 2; e.rdata = 16'h2222; e.cyc = cyc + 2;
         sb.push_back(e);
         idle(2);
         sreq = 1'b0;
         idle(2);
      end

      // Reset while a write is pending in WAIT.
      req(3'd0, 1'b1, 1'b0, 16'h0023, 16'h7777, 5'd16, 5'd0, -1, 16'h0000);
      chk("rst_mid_busy_before", 32'(busy[1]), 32'd1);
      rstb = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy[1]), 32'd0);
      chk("rst_mid_reg1", 32'(regs[1][1 * DW +: DW]), 32'h0000);
      idle(1);
      rstb = 1'b1;
      idle(6);
      chk("rst_mid_reg3", 32'(regs[1][3 * DW +: DW]), 32'h0000);

      idle(2);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
